// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch-stage controller and its instruction buffer.
package fetch_pkg;

    localparam logic [31:0] NOP             = 32'h0000_0000;
    localparam int          FETCH_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of {pc, inst} between the I-cache response and Decode.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         i_push,
    input  fetch_entry_t i_push_data,
    input  logic         i_pop,
    input  logic         i_flush,
    output logic [1:0]   o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t r_mem [FETCH_BUF_DEPTH];
    logic         r_rd_ptr;
    logic         r_wr_ptr;
    logic [1:0]   r_count;

    always_ff @(posedge clk_i) begin
        if (rst_i || i_flush) begin
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (i_push) r_wr_ptr <= ~r_wr_ptr;
            if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
        end
    end

    // Storage is data only; pointers alone define validity.
    always_ff @(posedge clk_i) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

    assign o_count = r_count;
    assign o_head  = (r_count != 2'd0) ? r_mem[r_rd_ptr] : '{pc: 32'h0, inst: NOP};

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage controller: owns the PC, issues one I-cache request at a time, discards stale responses.
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    output logic        ic_req_valid_o,
    input  logic        ic_req_ready_i,
    output logic [31:0] ic_req_addr_o,
    input  logic        ic_rsp_valid_i,
    input  logic [31:0] ic_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic [31:0] perf_fetch_o,
    output logic [31:0] perf_drop_o
);

    fetch_state_e r_state;
    fetch_state_e w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  r_req_pc;
    logic [1:0]   w_count;
    fetch_entry_t w_head;
    logic         w_req_fire;
    logic         w_push;
    logic         w_pop;

    assign ic_req_valid_o = !rst_i && (r_state == S_REQ) && !redir_i
                            && (32'(w_count) < FETCH_BUF_DEPTH);
    assign ic_req_addr_o  = r_pc;
    assign w_req_fire     = ic_req_valid_o && ic_req_ready_i;
    assign w_push         = !rst_i && (r_state == S_WAIT) && ic_rsp_valid_i && !redir_i;

    assign inst_valid_o   = !rst_i && (w_count != 2'd0) && !redir_i;
    assign w_pop          = inst_valid_o && inst_ready_i;
    assign inst_o         = rst_i ? NOP   : w_head.inst;
    assign inst_pc_o      = rst_i ? 32'h0 : w_head.pc;

    // A redirect with a request in flight must wait for the stale response before refetching.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_REQ:   if (w_req_fire) w_state_nxt = S_WAIT;
            S_WAIT:  begin
                if (redir_i)             w_state_nxt = ic_rsp_valid_i ? S_REQ : S_FLUSH;
                else if (ic_rsp_valid_i) w_state_nxt = S_REQ;
            end
            S_FLUSH: if (ic_rsp_valid_i) w_state_nxt = S_REQ;
            default: w_state_nxt = S_REQ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_REQ;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            if (redir_i)         r_pc <= redir_pc_i;
            else if (w_req_fire) r_pc <= r_pc + 32'd4;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_req_fire) r_req_pc <= r_pc;
    end

    fetch_buf u_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .i_push      (w_push),
        .i_push_data ('{pc: r_req_pc, inst: ic_rsp_data_i}),
        .i_pop       (w_pop),
        .i_flush     (redir_i),
        .o_count     (w_count),
        .o_head      (w_head)
    );

`ifdef FETCH_PERF_CNT_EN
    logic        w_drop;
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_drop;

    assign w_drop = ic_rsp_valid_i && ((r_state == S_FLUSH) || ((r_state == S_WAIT) && redir_i));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_perf_fetch <= 32'd0;
            r_perf_drop  <= 32'd0;
        end else begin
            if (w_push) r_perf_fetch <= r_perf_fetch + 32'd1;
            if (w_drop) r_perf_drop  <= r_perf_drop + 32'd1;
        end
    end

    assign perf_fetch_o = r_perf_fetch;
    assign perf_drop_o  = r_perf_drop;
`else
    assign perf_fetch_o = 32'd0;
    assign perf_drop_o  = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, a hand-written flush sequence, then random traffic vs a queue model.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk_i = 1'b0;
    logic        rst_i, redir_i, ic_req_ready_i, ic_rsp_valid_i, inst_ready_i;
    logic [31:0] redir_pc_i, ic_rsp_data_i;
    logic        ic_req_valid_o, inst_valid_o;
    logic [31:0] ic_req_addr_o, inst_o, inst_pc_o, perf_fetch_o, perf_drop_o;

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .redir_i(redir_i), .redir_pc_i(redir_pc_i),
        .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i),
        .ic_req_addr_o(ic_req_addr_o), .ic_rsp_valid_i(ic_rsp_valid_i),
        .ic_rsp_data_i(ic_rsp_data_i), .inst_valid_o(inst_valid_o),
        .inst_ready_i(inst_ready_i), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .perf_fetch_o(perf_fetch_o), .perf_drop_o(perf_drop_o)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    function automatic logic [31:0] perf_exp(input logic [31:0] v);
`ifdef FETCH_PERF_CNT_EN
        return v;
`else
        return 32'd0;
`endif
    endfunction

    // Reference model: PC, queue of delivered {pc,inst}, and whether a request is outstanding and live or stale.
    logic [31:0] m_pc, m_req_pc, m_fetch, m_drop;
    logic [63:0] m_q[$];
    int          m_out;   // 0 none, 1 live, 2 stale
    logic        e_rv, e_iv;
    logic [31:0] e_inst, e_ipc;

    function automatic void model_eval();
        e_rv   = !rst_i && (m_out == 0) && (m_q.size() < 2) && !redir_i;
        e_iv   = !rst_i && (m_q.size() != 0) && !redir_i;
        e_inst = (!rst_i && m_q.size() != 0) ? m_q[0][31:0]  : 32'h0;
        e_ipc  = (!rst_i && m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
    endfunction

    function automatic void model_step();
        if (rst_i) begin
            m_pc = RESET_PC; m_q.delete(); m_out = 0; m_fetch = 0; m_drop = 0;
            return;
        end
        if (e_iv && inst_ready_i) void'(m_q.pop_front());
        if (redir_i) begin
            m_pc = redir_pc_i;
            m_q.delete();
            if (m_out != 0) begin
                if (ic_rsp_valid_i) begin m_out = 0; m_drop = m_drop + 1; end
                else m_out = 2;
            end
        end else if (m_out == 0) begin
            if (e_rv && ic_req_ready_i) begin m_req_pc = m_pc; m_pc = m_pc + 32'd4; m_out = 1; end
        end else if (ic_rsp_valid_i) begin
            if (m_out == 1) begin m_q.push_back({m_req_pc, ic_rsp_data_i}); m_fetch = m_fetch + 1; end
            else m_drop = m_drop + 1;
            m_out = 0;
        end
    endfunction

    task automatic drive(input logic rst, input logic redir, input logic [31:0] rpc,
                         input logic rdy, input logic rsp, input logic [31:0] rdata, input logic irdy);
        rst_i = rst; redir_i = redir; redir_pc_i = rpc; ic_req_ready_i = rdy;
        ic_rsp_valid_i = rsp; ic_rsp_data_i = rdata; inst_ready_i = irdy;
        #1;
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] rpc;
        logic        rdy, rsp;
        logic [31:0] rdata;
        logic        irdy;
        logic        rv;
        logic [31:0] addr;
        logic        iv;
        logic [31:0] inst, ipc, fetch, drop;
    } vec_t;

    function automatic vec_t mk(input logic rst, redir, input logic [31:0] rpc, input logic rdy, rsp,
                                input logic [31:0] rdata, input logic irdy, rv, input logic [31:0] addr,
                                input logic iv, input logic [31:0] inst, ipc, fetch, drop);
        vec_t v;
        v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata;
        v.irdy = irdy; v.rv = rv; v.addr = addr; v.iv = iv; v.inst = inst; v.ipc = ipc;
        v.fetch = fetch; v.drop = drop;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        //            rst redir rpc           rdy rsp rdata irdy  rv addr          iv inst ipc           fetch drop
        tbl[0]  = mk(1, 0, 32'h0,         1, 0, 32'h0,  0,   0, 32'h0,         0, 32'h0,  32'h0,         0, 0);
        tbl[1]  = mk(0, 0, 32'h0,         1, 0, 32'h0,  0,   1, 32'h0,         0, 32'h0,  32'h0,         0, 0);
        tbl[2]  = mk(0, 0, 32'h0,         1, 1, 32'h13, 0,   0, 32'h0,         0, 32'h0,  32'h0,         0, 0);
        tbl[3]  = mk(0, 0, 32'h0,         1, 0, 32'h0,  0,   1, 32'h4,         1, 32'h13, 32'h0,         1, 0);
        tbl[4]  = mk(0, 0, 32'h0,         1, 1, 32'h17, 0,   0, 32'h0,         1, 32'h13, 32'h0,         1, 0);
        tbl[5]  = mk(0, 0, 32'h0,         1, 0, 32'h0,  0,   0, 32'h0,         1, 32'h13, 32'h0,         2, 0);
        tbl[6]  = mk(0, 0, 32'h0,         1, 0, 32'h0,  1,   0, 32'h0,         1, 32'h13, 32'h0,         2, 0);
        tbl[7]  = mk(0, 0, 32'h0,         1, 0, 32'h0,  1,   1, 32'h8,         1, 32'h17, 32'h4,         2, 0);
        tbl[8]  = mk(0, 1, 32'h100,       1, 0, 32'h0,  1,   0, 32'h0,         0, 32'h0,  32'h0,         2, 0);
        tbl[9]  = mk(0, 0, 32'h0,         1, 1, 32'hAA, 1,   0, 32'h0,         0, 32'h0,  32'h0,         2, 0);
        tbl[10] = mk(0, 0, 32'h0,         1, 0, 32'h0,  1,   1, 32'h100,       0, 32'h0,  32'h0,         2, 1);
        tbl[11] = mk(0, 1, 32'hFFFF_FFFC, 1, 1, 32'hBB, 1,   0, 32'h0,         0, 32'h0,  32'h0,         2, 1);
        tbl[12] = mk(0, 0, 32'h0,         1, 0, 32'h0,  1,   1, 32'hFFFF_FFFC, 0, 32'h0,  32'h0,         2, 2);
        tbl[13] = mk(0, 0, 32'h0,         1, 1, 32'h33, 0,   0, 32'h0,         0, 32'h0,  32'h0,         2, 2);
        tbl[14] = mk(0, 0, 32'h0,         1, 0, 32'h0,  0,   1, 32'h0,         1, 32'h33, 32'hFFFF_FFFC, 3, 2);
        tbl[15] = mk(1, 0, 32'h0,         1, 0, 32'h0,  0,   0, 32'h0,         0, 32'h0,  32'h0,         3, 2);
        tbl[16] = mk(0, 0, 32'h0,         0, 1, 32'h55, 0,   1, 32'h0,         0, 32'h0,  32'h0,         0, 0);
        tbl[17] = mk(0, 0, 32'h0,         1, 0, 32'h0,  0,   1, 32'h0,         0, 32'h0,  32'h0,         0, 0);

        drive(1, 0, 0, 0, 0, 0, 0);
        @(negedge clk_i);
        tick();
        tick();

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rdy, tbl[i].rsp, tbl[i].rdata, tbl[i].irdy);
            chk($sformatf("vec%0d req_valid", i), 32'(ic_req_valid_o), 32'(tbl[i].rv));
            if (tbl[i].rv) chk($sformatf("vec%0d req_addr", i), ic_req_addr_o, tbl[i].addr);
            chk($sformatf("vec%0d inst_valid", i), 32'(inst_valid_o), 32'(tbl[i].iv));
            chk($sformatf("vec%0d inst", i), inst_o, tbl[i].inst);
            chk($sformatf("vec%0d inst_pc", i), inst_pc_o, tbl[i].ipc);
            chk($sformatf("vec%0d perf_fetch", i), perf_fetch_o, perf_exp(tbl[i].fetch));
            chk($sformatf("vec%0d perf_drop", i), perf_drop_o, perf_exp(tbl[i].drop));
            tick();
        end

        // Redirect in WAIT, stale response held off, second redirect coincident with the stale response.
        drive(0, 1, 32'h200, 1, 0, 32'h0, 1);
        chk("flush redir1 req_valid", 32'(ic_req_valid_o), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1, 0, 32'h0, 1);
            chk($sformatf("flush hold%0d req_valid", i), 32'(ic_req_valid_o), 32'd0);
            tick();
        end
        drive(0, 1, 32'h300, 1, 1, 32'hDEAD, 1);
        chk("flush redir2 req_valid", 32'(ic_req_valid_o), 32'd0);
        tick();
        drive(0, 0, 32'h0, 0, 0, 32'h0, 1);
        chk("flush resume req_valid", 32'(ic_req_valid_o), 32'd1);
        chk("flush resume req_addr", ic_req_addr_o, 32'h300);
        chk("flush resume inst_valid", 32'(inst_valid_o), 32'd0);
        chk("flush resume perf_drop", perf_drop_o, perf_exp(32'd1));
        tick();

        for (int c = 0; c < 3000; c++) begin
            logic [31:0] rpc;
            rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
            drive($urandom_range(0, 63) == 0, $urandom_range(0, 7) == 0, rpc,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom(),
                  $urandom_range(0, 1) == 1);
            chk("rand req_valid", 32'(ic_req_valid_o), 32'(e_rv));
            if (e_rv) chk("rand req_addr", ic_req_addr_o, m_pc);
            chk("rand inst_valid", 32'(inst_valid_o), 32'(e_iv));
            chk("rand inst", inst_o, e_inst);
            chk("rand inst_pc", inst_pc_o, e_ipc);
            chk("rand perf_fetch", perf_fetch_o, perf_exp(m_fetch));
            chk("rand perf_drop", perf_drop_o, perf_exp(m_drop));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
